// File: rtl/jtcop_snd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtcop_snd_pkg
// Description : Shared sound-subsystem definitions: NMI FSM state encoding,
//               default command width / queue depth and a small helper for
//               sizing address buses.
// Config      : JTCOP_SNDLATCH_FIFO_EN (selects FIFO vs single register in
//               jtcop_sndlatch; nothing in this package depends on it)
// Revision    : 1.0 - initial release
// ============================================================================
package jtcop_snd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2,
        ST_GAP     = 2'd3
    } nmi_state_t;

    localparam int c_DEF_DW    = 8;
    localparam int c_DEF_DEPTH = 4;

    // Address width for a storage of 'depth' entries; never below one bit so
    // that a single-entry store still has a legal port.
    function automatic int sndq_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtcop_sndlatch_if.sv
`default_nettype none
// ============================================================================
// Module      : jtcop_sndlatch_if
// Description : Main-CPU / sound-CPU side signals of the sound command queue.
// Ports       : snreq  - main CPU sound request (level, push on rise)
//               latch  - command byte from the main CPU
//               rd     - sound CPU latch chip-select
//               dout   - head-of-queue byte (all ones when empty)
//               nmi_n  - NMI to the sound CPU, active-low
//               empty / full / ovf - queue status, ovf sticky
// Modports    : master - drives snreq/latch/rd; slave - the queue itself
// Config      : JTCOP_SNDLATCH_FIFO_EN (no effect on the interface)
// Revision    : 1.0 - initial release
// ============================================================================
interface jtcop_sndlatch_if
    import jtcop_snd_pkg::*;
#(
    parameter int DW = c_DEF_DW
);
    logic          snreq;
    logic [DW-1:0] latch;
    logic          rd;
    logic [DW-1:0] dout;
    logic          nmi_n;
    logic          empty;
    logic          full;
    logic          ovf;

    modport master (output snreq, latch, rd,
                    input  dout, nmi_n, empty, full, ovf);
    modport slave  (input  snreq, latch, rd,
                    output dout, nmi_n, empty, full, ovf);
endinterface
`default_nettype wire

// File: rtl/jtcop_sndq_mem.sv
`default_nettype none
// ============================================================================
// Module      : jtcop_sndq_mem
// Description : DEPTH x DW register-file storage for the sound command queue.
//               Synchronous write, asynchronous read.
// Ports       : clk - clock; we/wa/wd - write enable, address, data;
//               ra/rq - read address, read data
// Config      : JTCOP_SNDLATCH_FIFO_EN (no effect; DEPTH chosen by parent)
// Revision    : 1.0 - initial release
// ============================================================================
module jtcop_sndq_mem #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rq
);

    generate
        if (DEPTH == 1) begin : g_single
            // One entry: the address buses carry no information.
            logic [DW-1:0] r_data;
            logic          w_unused_addr;

            assign w_unused_addr = &{1'b0, wa, ra};

            always_ff @(posedge clk) begin
                if (we) r_data <= wd;
            end
            assign rq = r_data;
        end else begin : g_array
            logic [DW-1:0] r_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (we) r_mem[wa] <= wd;
            end
            assign rq = r_mem[ra];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/jtcop_sndlatch.sv
`default_nettype none
// ============================================================================
// Module      : jtcop_sndlatch
// Description : Sound-command queue between the main CPU and the sound CPU.
//               One byte is captured per rising edge of snreq, queued, and
//               the sound CPU NMI is driven until every byte has been read.
//               A byte is consumed on the falling edge of rd.
// Ports       : clk   - system clock
//               rst_n - synchronous active-low reset
//               bus   - jtcop_sndlatch_if.slave (snreq, latch, rd, dout,
//                       nmi_n, empty, full, ovf)
// Config      : JTCOP_SNDLATCH_FIFO_EN defined  -> DEPTH-entry FIFO with an
//                                                  NMI_GAP re-arm gap
//               JTCOP_SNDLATCH_FIFO_EN undefined -> single overwriting
//                                                  register, no gap
// Revision    : 1.0 - initial release
// ============================================================================
module jtcop_sndlatch
    import jtcop_snd_pkg::*;
#(
    parameter int DW      = c_DEF_DW,
    parameter int DEPTH   = c_DEF_DEPTH,
    parameter int NMI_GAP = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    jtcop_sndlatch_if.slave      bus
);

`ifdef JTCOP_SNDLATCH_FIFO_EN
    localparam int c_DEPTH = DEPTH;
`else
    localparam int c_DEPTH = 1;
    localparam int c_unused_depth = DEPTH;
    localparam int c_unused_gap   = NMI_GAP;
`endif
    localparam int c_AW = sndq_aw(c_DEPTH);
    localparam int c_CW = $clog2(c_DEPTH) + 1;

    logic            r_snreq_l;
    logic            r_rd_l;
    logic            r_rd_rise;
    logic            r_rd_fall;
    logic            w_push;
    logic            w_rd_rise;
    logic            w_rd_fall;
    logic            w_pop;
    logic            w_wr_ok;
    logic            w_drop;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] w_count_nxt;
    logic [c_AW-1:0] w_wa;
    logic [c_AW-1:0] w_ra;
    logic [DW-1:0]   w_rq;
    logic            r_empty;
    logic            r_full;
    logic            r_ovf;
    logic            r_nmi_n;
    nmi_state_t      r_st;
    nmi_state_t      w_st_nxt;

    assign w_push    = bus.snreq & ~r_snreq_l;
    assign w_rd_rise = bus.rd & ~r_rd_l;
    assign w_rd_fall = r_rd_l & ~bus.rd;
    assign w_pop     = w_rd_fall & (r_count != '0);

`ifdef JTCOP_SNDLATCH_FIFO_EN
    localparam int c_GW = (NMI_GAP > 1) ? $clog2(NMI_GAP) : 1;

    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_GW-1:0] r_gap;
    logic [c_GW-1:0] w_gap_nxt;
    logic            w_full_now;

    // A pop on the same edge frees a slot, so a push into a full queue is
    // still accepted then; the written slot is the one just vacated.
    assign w_full_now  = (r_count == c_CW'(c_DEPTH));
    assign w_wr_ok     = w_push & (~w_full_now | w_pop);
    assign w_drop      = w_push & w_full_now & ~w_pop;
    assign w_count_nxt = r_count + c_CW'(w_wr_ok) - c_CW'(w_pop);
    assign w_wa        = r_wr_ptr;
    assign w_ra        = r_rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_gap    <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_AW'(w_wr_ok);
            r_rd_ptr <= r_rd_ptr + c_AW'(w_pop);
            r_gap    <= w_gap_nxt;
        end
    end
`else
    // Single register: a push always overwrites; it only counts as an
    // overflow if the previous byte is still unread after any same-edge pop.
    assign w_wr_ok     = w_push;
    assign w_drop      = w_push & (r_count != '0) & ~w_pop;
    assign w_count_nxt = w_push ? c_CW'(1) : (w_pop ? '0 : r_count);
    assign w_wa        = '0;
    assign w_ra        = '0;
`endif

    jtcop_sndq_mem #(
        .DW    (DW),
        .DEPTH (c_DEPTH),
        .AW    (c_AW)
    ) u_mem (
        .clk (clk),
        .we  (w_wr_ok),
        .wa  (w_wa),
        .wd  (bus.latch),
        .ra  (w_ra),
        .rq  (w_rq)
    );

    // Datapath registers: edge detectors, occupancy and registered flags.
    // The FSM sees rd edges one cycle late through r_rd_rise/r_rd_fall; a
    // rise only matters while NMI is asserted, so it is qualified there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snreq_l <= 1'b0;
            r_rd_l    <= 1'b0;
            r_rd_rise <= 1'b0;
            r_rd_fall <= 1'b0;
            r_count   <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_snreq_l <= bus.snreq;
            r_rd_l    <= bus.rd;
            r_rd_rise <= w_rd_rise & (r_st == ST_ASSERT);
            r_rd_fall <= w_rd_fall;
            r_count   <= w_count_nxt;
            r_empty   <= (w_count_nxt == '0);
            r_full    <= (w_count_nxt == c_CW'(c_DEPTH));
            r_ovf     <= r_ovf | w_drop;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_st    <= ST_IDLE;
            r_nmi_n <= 1'b1;
        end else begin
            r_st    <= w_st_nxt;
            r_nmi_n <= (w_st_nxt != ST_ASSERT);
        end
    end

    always_comb begin
        w_st_nxt = r_st;
`ifdef JTCOP_SNDLATCH_FIFO_EN
        w_gap_nxt = r_gap;
`endif
        case (r_st)
            ST_IDLE: begin
                if (r_count != '0) w_st_nxt = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (r_rd_rise) w_st_nxt = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (r_rd_fall) begin
`ifdef JTCOP_SNDLATCH_FIFO_EN
                    w_st_nxt  = ST_GAP;
                    w_gap_nxt = c_GW'(NMI_GAP - 1);
`else
                    w_st_nxt  = ST_IDLE;
`endif
                end
            end
            ST_GAP: begin
`ifdef JTCOP_SNDLATCH_FIFO_EN
                if (r_gap == '0) begin
                    w_st_nxt = (r_count != '0) ? ST_ASSERT : ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap - c_GW'(1);
                end
`else
                w_st_nxt = ST_IDLE;
`endif
            end
            default: w_st_nxt = ST_IDLE;
        endcase
    end

    assign bus.dout  = (r_count != '0) ? w_rq : {DW{1'b1}};
    assign bus.nmi_n = r_nmi_n;
    assign bus.empty = r_empty;
    assign bus.full  = r_full;
    assign bus.ovf   = r_ovf;

endmodule
`default_nettype wire
